// File: rtl/determinante_pkg.sv
// Shared types and constants for the sequential determinant engine:
// FSM states, result width and the per-term element/sign table.
package determinante_pkg;

  typedef enum logic {IDLE, CALC} state_t;

  // Width that holds the worst-case 3x3 sum of six signed triple products.
  function automatic int det_w(input int elem_w);
    return 3 * elem_w + 3;
  endfunction

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic       neg;
  } termo_t;

  localparam logic [2:0] LAST_2X2 = 3'd1;
  localparam logic [2:0] LAST_3X3 = 3'd5;

  // Element indices and sign of each term. The 2x2 case uses the top-left
  // submatrix and only the a/b factors.
  function automatic termo_t termo_tab(input logic modo, input logic [2:0] idx);
    termo_t t;
    if (!modo) begin
      t = (idx == 3'd0) ? '{a: 4'd0, b: 4'd4, c: 4'd0, neg: 1'b0}
                        : '{a: 4'd1, b: 4'd3, c: 4'd0, neg: 1'b1};
    end else begin
      case (idx)
        3'd0:    t = '{a: 4'd0, b: 4'd4, c: 4'd8, neg: 1'b0};
        3'd1:    t = '{a: 4'd1, b: 4'd5, c: 4'd6, neg: 1'b0};
        3'd2:    t = '{a: 4'd2, b: 4'd3, c: 4'd7, neg: 1'b0};
        3'd3:    t = '{a: 4'd2, b: 4'd4, c: 4'd6, neg: 1'b1};
        3'd4:    t = '{a: 4'd1, b: 4'd3, c: 4'd8, neg: 1'b1};
        default: t = '{a: 4'd0, b: 4'd5, c: 4'd7, neg: 1'b1};
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/determinante_termo.sv
// Combinational term generator: one signed, sign-extended product of the
// captured elements selected by the term index.
module determinante_termo
  import determinante_pkg::*;
#(
  parameter  int ELEM_W = 8,
  localparam int DET_W  = det_w(ELEM_W)
) (
  input  logic [9*ELEM_W-1:0]    matriz,
  input  logic                   modo,
  input  logic [2:0]             idx,
  output logic signed [DET_W-1:0] termo
);

  logic signed [ELEM_W-1:0] m [9];

  for (genvar k = 0; k < 9; k++) begin : g_elem
    assign m[k] = matriz[(8-k)*ELEM_W +: ELEM_W];
  end

  function automatic logic signed [DET_W-1:0] sext(input logic signed [ELEM_W-1:0] e);
    return {{(DET_W-ELEM_W){e[ELEM_W-1]}}, e};
  endfunction

  termo_t                   t;
  logic signed [DET_W-1:0]  prod;

  // NOTE: every variable written here gets a value first on every path so no latch is inferred.
  always_comb begin
    t    = termo_tab(modo, idx);
    prod = sext(m[t.a]) * sext(m[t.b]);
    if (modo) prod = prod * sext(m[t.c]);
    termo = t.neg ? -prod : prod;
  end

endmodule

// File: rtl/determinante_seq.sv
// Sequential determinant of a 2x2 or 3x3 signed matrix: one term accumulated
// per cycle, det updated with a one-cycle done pulse.
module determinante_seq
  import determinante_pkg::*;
#(
  parameter  int ELEM_W = 8,
  localparam int DET_W  = det_w(ELEM_W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    modo,
  input  logic [9*ELEM_W-1:0]     matriz,
  output logic                    busy,
  output logic                    done,
  output logic signed [DET_W-1:0] det
);

  state_t                  state, state_next;
  logic [9*ELEM_W-1:0]     op_matriz;
  logic                    op_modo;
  logic [2:0]              idx;
  logic signed [DET_W-1:0] acc, sum, termo;
  logic                    last;

  determinante_termo #(.ELEM_W(ELEM_W)) u_termo (
    .matriz (op_matriz),
    .modo   (op_modo),
    .idx    (idx),
    .termo  (termo)
  );

  always_comb begin
    state_next = state;
    sum        = acc + termo;
    last       = (idx == (op_modo ? LAST_3X3 : LAST_2X2));
    if (state == IDLE) begin
      if (start) state_next = CALC;
    end else if (last) begin
      state_next = IDLE;
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: captured operands are reset too, so an aborted run leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_matriz <= '0;
      op_modo   <= 1'b0;
      idx       <= '0;
      acc       <= '0;
      det       <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          op_matriz <= matriz;
          op_modo   <= modo;
          acc       <= '0;
          idx       <= '0;
        end
      end else begin
        acc <= sum;
        idx <= idx + 3'd1;
        if (last) begin
          det  <= sum;
          done <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == CALC);

endmodule
